// File: rtl/sdfm_pkg.sv
// Shared constants for the sigma-delta filter path: decimation width,
// maximum filter order and settle-counter sizing.
package sdfm_pkg;

    localparam int ORDER_MAX = 3;
    localparam int DEC_W     = 8;
    localparam int SETTLE_W  = 2;

    // R^order with R up to 2^DEC_W needs order*DEC_W+1 bits.
    function automatic int calc_acc_w(input int order);
        return order * DEC_W + 1;
    endfunction

endpackage

// File: rtl/sinc_integrator.sv
// One CIC integrator stage: accumulates inc_i every cycle while enabled,
// cleared synchronously by reset or by dropping the enable.
module sinc_integrator #(
    parameter int ACC_W = 25
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Modulo-2^ACC_W wrap is intended; the comb section cancels it.
    always_comb begin
        acc_d = acc_q + inc_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sinc_filter.sv
// CIC/sincN decimation filter for one sigma-delta bitstream.
// Optional macro SDFM_DATA_SYNC_EN inserts a 2-flop synchronizer on data_in.
module sinc_filter
    import sdfm_pkg::*;
#(
    parameter int ORDER = 3,
    parameter int ACC_W = 25
) (
    input  logic             clk_in,
    input  logic             SYSRSTn,
    input  logic             filter_en,
    input  logic             data_in,
    input  logic             osr,
    output logic [ACC_W-1:0] data_out,
    output logic             data_valid
);

    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(ORDER);

    if (ORDER < 1 || ORDER > ORDER_MAX || ACC_W < calc_acc_w(ORDER)) begin : g_bad_param
        $error("sinc_filter: illegal ORDER/ACC_W combination");
    end

    logic sample;

`ifdef SDFM_DATA_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_in) begin
        if (!SYSRSTn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], data_in};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = data_in;
`endif

    logic [ORDER:0][ACC_W-1:0] integ;

    assign integ[0] = ACC_W'(sample);

    for (genvar k = 1; k <= ORDER; k++) begin : g_integ
        sinc_integrator #(
            .ACC_W(ACC_W)
        ) u_integ (
            .clk_i (clk_in),
            .rst_ni(SYSRSTn),
            .en_i  (filter_en),
            .inc_i (integ[k-1]),
            .acc_o (integ[k])
        );
    end

    logic [ORDER-1:0][ACC_W-1:0] z_q;
    logic [ORDER:0][ACC_W-1:0]   comb_d;
    logic [ACC_W-1:0]            data_out_q;
    logic                        data_valid_q;
    logic [SETTLE_W-1:0]         settle_q;

    // Comb chain evaluated in the strobe cycle from the current last-integrator value.
    always_comb begin
        comb_d    = '0;
        comb_d[0] = integ[ORDER];
        for (int k = 0; k < ORDER; k++) begin
            comb_d[k+1] = comb_d[k] - z_q[k];
        end
    end

    // The settle counter masks valid until every comb delay holds a post-clear sample.
    always_ff @(posedge clk_in) begin
        if (!SYSRSTn || !filter_en) begin
            z_q          <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            settle_q     <= '0;
        end else begin
            data_valid_q <= 1'b0;
            if (osr) begin
                z_q          <= comb_d[ORDER-1:0];
                data_out_q   <= comb_d[ORDER];
                data_valid_q <= (settle_q == SETTLE_DONE);
                if (settle_q != SETTLE_DONE) begin
                    settle_q <= settle_q + 1'b1;
                end
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_sinc_filter.sv
// Scoreboard bench for sinc_filter: an ORDER=3 instance under decimated strobes
// and an ORDER=1 instance with osr held high.
module tb_sinc_filter;

    typedef struct packed {
        logic [31:0] cycle;
        logic [24:0] value;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstnA = 1'b0;
    logic        enA   = 1'b0;
    logic        dinA  = 1'b0;
    logic        osrA  = 1'b0;
    logic [24:0] doutA;
    logic        dvalidA;

    logic        rstnB = 1'b0;
    logic        enB   = 1'b1;
    logic        dinB  = 1'b0;
    logic        osrB  = 1'b1;
    logic [8:0]  doutB;
    logic        dvalidB;

    sinc_filter #(
        .ORDER(3),
        .ACC_W(25)
    ) dutA (
        .clk_in    (clk),
        .SYSRSTn   (rstnA),
        .filter_en (enA),
        .data_in   (dinA),
        .osr       (osrA),
        .data_out  (doutA),
        .data_valid(dvalidA)
    );

    sinc_filter #(
        .ORDER(1),
        .ACC_W(9)
    ) dutB (
        .clk_in    (clk),
        .SYSRSTn   (rstnB),
        .filter_en (enB),
        .data_in   (dinB),
        .osr       (osrB),
        .data_out  (doutB),
        .data_valid(dvalidB)
    );

    exp_t expA[$];
    exp_t expB[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   strobesA    = 0;
    int   strobesB    = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic reportMissing(input string name, input int pending);
        vectors++;
        if (pending != 0) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d outstanding expected pulses, required 0", name, pending);
        end
    endtask

    // Monitors pop one expectation per valid pulse; an unexpected pulse is a miscompare.
    always @(negedge clk) begin
        exp_t e;
        if (dvalidA === 1'b1) begin
            if (expA.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL A unexpected valid: got data_valid=1 data_out=%0d, required no pulse (cycle %0d)", doutA, cyc);
            end else begin
                e = expA.pop_front();
                checkOutput("A data_out", 32'(doutA), 32'(e.value));
                checkOutput("A valid cycle", cyc, e.cycle);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dvalidB === 1'b1) begin
            if (expB.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL B unexpected valid: got data_valid=1 data_out=%0d, required no pulse (cycle %0d)", doutB, cyc);
            end else begin
                e = expB.pop_front();
                checkOutput("B data_out", 32'(doutB), 32'(e.value));
                checkOutput("B valid cycle", cyc, e.cycle);
            end
        end
    end

    // mode: 0 = constant 0, 1 = constant 1, 2 = alternating 1,0.
    // kind: 1 = SYSRSTn pulse, 2 = filter_en pulse; applied at k=0 and at k=midAt.
    task automatic applyStimulus(input int r, input int nCyc, input int mode,
                                 input logic [24:0] expVal, input int midAt, input int kind);
        bit pendingClear = 1'b0;
        bit clearNow;
        for (int k = 0; k < nCyc; k++) begin
            @(posedge clk);
            #1;
            if (pendingClear) begin
                checkOutput("clear data_out", 32'(doutA), 32'd0);
                checkOutput("clear data_valid", 32'(dvalidA), 32'd0);
                pendingClear = 1'b0;
            end
            clearNow = (k == 0) || (k == midAt);
            rstnA = !(clearNow && kind == 1);
            enA   = !(clearNow && kind == 2);
            dinA  = (mode == 1) ? 1'b1 : (mode == 2) ? ((k % 2) == 0) : 1'b0;
            osrA  = ((k % r) == (r - 1));
            if (clearNow) begin
                strobesA     = 0;
                pendingClear = 1'b1;
            end else if (osrA) begin
                strobesA++;
                if (strobesA > 3) begin
                    expA.push_back('{cycle: 32'(cyc + 1), value: expVal});
                end
            end
        end
    endtask

    task automatic applyStimulusR1(input int nCyc);
        logic [31:0] pattern;
        logic        prevBit;
        pattern = 32'hB38D_5A61;
        prevBit = 1'b0;
        for (int k = 0; k < nCyc; k++) begin
            @(posedge clk);
            #1;
            rstnB = (k != 0);
            osrB  = 1'b1;
            dinB  = pattern[k % 32];
            if (k == 0) begin
                strobesB = 0;
            end else begin
                strobesB++;
                if (strobesB >= 2) begin
                    expB.push_back('{cycle: 32'(cyc + 1), value: 25'(prevBit)});
                end
            end
            prevBit = dinB;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        fork
            begin
                applyStimulus(16, 128, 1, 25'd4096, -1, 1);
                applyStimulus(16, 128, 2, 25'd2048, -1, 2);
                applyStimulus(256, 1536, 1, 25'h100_0000, -1, 2);
                applyStimulus(16, 128, 0, 25'd0, -1, 1);
                applyStimulus(16, 176, 1, 25'd4096, 87, 1);
                applyStimulus(16, 176, 1, 25'd4096, 87, 2);
                applyStimulus(16, 112, 1, 25'd4096, 15, 2);
                @(posedge clk);
                #1;
                osrA = 1'b0;
            end
            begin
                applyStimulusR1(40);
                @(posedge clk);
                #1;
                osrB = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        reportMissing("A pending expectations", expA.size());
        reportMissing("B pending expectations", expB.size());
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
